// File: rtl/pip_hazard_sched_pkg.sv
// Shared constants and types for the pipeline hazard scheduler.
package pip_hazard_sched_pkg;

   localparam int unsigned RegIdxW = 5;
   localparam logic [RegIdxW-1:0] RegX0 = '0;

   typedef enum logic {
      StRun    = 1'b0,
      StMdBusy = 1'b1
   } md_state_e;

endpackage

// File: rtl/pip_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module pip_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pip_hazard_sched.sv
// Central stall/flush scheduler: merges memory wait, MUL/DIV, branch and load-use hazards
// into per-register stall/flush controls and sequences the MUL/DIV handshake.
module pip_hazard_sched
   import pip_hazard_sched_pkg::*;
#(
   parameter int unsigned MD_TIMEOUT = 64,
   parameter int unsigned CNT_W      = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [RegIdxW-1:0] id_rs1_i,
   input  logic [RegIdxW-1:0] id_rs2_i,
   input  logic               id_uses_rs1_i,
   input  logic               id_uses_rs2_i,
   input  logic [RegIdxW-1:0] ex_rd_i,
   input  logic               ex_mem_read_i,
   input  logic               ex_md_op_i,
   input  logic               md_done_i,
   input  logic               mem_access_i,
   input  logic               dmem_ready_i,
   input  logic               branch_taken_i,
   input  logic               branch_mispredicted_i,
   input  logic               perf_clr_i,
   output logic               stall_fetch_dec_o,
   output logic               stall_dec_ex_o,
   output logic               stall_ex_mem_o,
   output logic               flush_fetch_dec_o,
   output logic               flush_dec_ex_o,
   output logic               flush_ex_mem_o,
   output logic               md_start_o,
   output logic               md_timeout_o,
   output logic [CNT_W-1:0]   stall_cnt_o,
   output logic [CNT_W-1:0]   flush_cnt_o
);

   // Busy-cycle count at which the watchdog fires; the issue cycle makes MD_TIMEOUT total.
   localparam logic [7:0] WaitLast = 8'(MD_TIMEOUT - 2);

   md_state_e  state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic       timeout_q, timeout_d;
   logic       mem_wait, lu;

   assign mem_wait = mem_access_i & ~dmem_ready_i;
   assign lu = ex_mem_read_i & (ex_rd_i != RegX0) &
               ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) |
                (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StRun;
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      timeout_d = timeout_q;
      if (!mem_wait) begin
         unique case (state_q)
            StMdBusy: begin
               if (md_done_i) begin
                  state_d = StRun;
                  wait_d  = '0;
               end else if (wait_q == WaitLast) begin
                  state_d   = StRun;
                  wait_d    = '0;
                  timeout_d = 1'b1;
               end else begin
                  wait_d = wait_q + 8'd1;
               end
            end
            StRun: begin
               if (ex_md_op_i) begin
                  state_d = StMdBusy;
                  wait_d  = '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      stall_fetch_dec_o = 1'b0;
      stall_dec_ex_o    = 1'b0;
      stall_ex_mem_o    = 1'b0;
      flush_fetch_dec_o = 1'b0;
      flush_dec_ex_o    = 1'b0;
      flush_ex_mem_o    = 1'b0;
      md_start_o        = 1'b0;
      if (!rst_ni) begin
         // Controls stay quiet while reset is held, whatever the inputs show.
      end else if (mem_wait) begin
         stall_fetch_dec_o = 1'b1;
         stall_dec_ex_o    = 1'b1;
         stall_ex_mem_o    = 1'b1;
      end else if (state_q == StMdBusy) begin
         if (!md_done_i) begin
            stall_fetch_dec_o = 1'b1;
            stall_dec_ex_o    = 1'b1;
            flush_ex_mem_o    = 1'b1;
         end
      end else if (ex_md_op_i) begin
         md_start_o        = 1'b1;
         stall_fetch_dec_o = 1'b1;
         stall_dec_ex_o    = 1'b1;
         flush_ex_mem_o    = 1'b1;
      end else if (branch_mispredicted_i) begin
         flush_fetch_dec_o = 1'b1;
         flush_dec_ex_o    = 1'b1;
      end else if (branch_taken_i) begin
         flush_fetch_dec_o = 1'b1;
      end else if (lu) begin
         stall_fetch_dec_o = 1'b1;
         flush_dec_ex_o    = 1'b1;
      end
   end

   assign md_timeout_o = timeout_q;

   pip_sat_counter #(
      .CNT_W(CNT_W)
   ) u_stall_cnt (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .inc_i (stall_fetch_dec_o),
      .clr_i (perf_clr_i),
      .cnt_o (stall_cnt_o)
   );

   pip_sat_counter #(
      .CNT_W(CNT_W)
   ) u_flush_cnt (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .inc_i (flush_fetch_dec_o | flush_dec_ex_o),
      .clr_i (perf_clr_i),
      .cnt_o (flush_cnt_o)
   );

endmodule

// File: tb/tb_pip_hazard_sched.sv
// Self-checking bench for pip_hazard_sched: vector table, directed corner cases, random run.
module tb_pip_hazard_sched;

   localparam int unsigned MdTimeout = 8;
   localparam int unsigned CntW      = 4;
   localparam int unsigned CntMax    = 15;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       mr;
      logic       md;
      logic       done;
      logic       ma;
      logic       rdy;
      logic       bt;
      logic       bm;
      logic       clr;
   } in_t;

   // exp bit order: {stall_fd, stall_de, stall_em, flush_fd, flush_de, flush_em, md_start}
   typedef struct {
      in_t        in;
      logic [6:0] exp;
   } vec_t;

   logic clk, rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_md_op, md_done;
   logic mem_access, dmem_ready, branch_taken, branch_mispredicted, perf_clr;
   logic s_fd, s_de, s_em, f_fd, f_de, f_em, md_start, md_timeout;
   logic [CntW-1:0] stall_cnt, flush_cnt;
   logic [6:0] out_vec;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit m_busy;
   int m_busy_cycles;
   bit m_to;
   int m_stall;
   int m_flush;

   assign out_vec = {s_fd, s_de, s_em, f_fd, f_de, f_em, md_start};

   pip_hazard_sched #(
      .MD_TIMEOUT(MdTimeout),
      .CNT_W     (CntW)
   ) dut (
      .clk_i                (clk),
      .rst_ni               (rst_n),
      .id_rs1_i             (id_rs1),
      .id_rs2_i             (id_rs2),
      .id_uses_rs1_i        (id_uses_rs1),
      .id_uses_rs2_i        (id_uses_rs2),
      .ex_rd_i              (ex_rd),
      .ex_mem_read_i        (ex_mem_read),
      .ex_md_op_i           (ex_md_op),
      .md_done_i            (md_done),
      .mem_access_i         (mem_access),
      .dmem_ready_i         (dmem_ready),
      .branch_taken_i       (branch_taken),
      .branch_mispredicted_i(branch_mispredicted),
      .perf_clr_i           (perf_clr),
      .stall_fetch_dec_o    (s_fd),
      .stall_dec_ex_o       (s_de),
      .stall_ex_mem_o       (s_em),
      .flush_fetch_dec_o    (f_fd),
      .flush_dec_ex_o       (f_de),
      .flush_ex_mem_o       (f_em),
      .md_start_o           (md_start),
      .md_timeout_o         (md_timeout),
      .stall_cnt_o          (stall_cnt),
      .flush_cnt_o          (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic in_t idle();
      in_t v;
      v = '{rs1: 5'd0, rs2: 5'd0, u1: 1'b0, u2: 1'b0, rd: 5'd0, mr: 1'b0, md: 1'b0,
            done: 1'b0, ma: 1'b0, rdy: 1'b1, bt: 1'b0, bm: 1'b0, clr: 1'b0};
      return v;
   endfunction

   function automatic bit load_use(input in_t v);
      if (!v.mr || v.rd == 5'd0) return 1'b0;
      return (v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd);
   endfunction

   function automatic logic [6:0] model_out(input in_t v);
      if (v.ma && !v.rdy) return 7'b1110000;
      if (m_busy)         return v.done ? 7'b0000000 : 7'b1100010;
      if (v.md)           return 7'b1100011;
      if (v.bm)           return 7'b0001100;
      if (v.bt)           return 7'b0001000;
      if (load_use(v))    return 7'b1000100;
      return 7'b0000000;
   endfunction

   task automatic model_commit(input in_t v, input logic [6:0] o);
      if (!(v.ma && !v.rdy)) begin
         if (m_busy) begin
            if (v.done) begin
               m_busy = 1'b0;
            end else begin
               m_busy_cycles++;
               // With the issue cycle, the unit may occupy the pipe for MdTimeout cycles.
               if (m_busy_cycles == MdTimeout - 1) begin
                  m_busy = 1'b0;
                  m_to   = 1'b1;
               end
            end
         end else if (v.md) begin
            m_busy        = 1'b1;
            m_busy_cycles = 0;
         end
      end
      if (v.clr) m_stall = 0;
      else if (o[6] && m_stall < CntMax) m_stall++;
      if (v.clr) m_flush = 0;
      else if ((o[3] || o[2]) && m_flush < CntMax) m_flush++;
   endtask

   task automatic model_reset();
      m_busy        = 1'b0;
      m_busy_cycles = 0;
      m_to          = 1'b0;
      m_stall       = 0;
      m_flush       = 0;
   endtask

   task automatic drive(input in_t v);
      id_rs1              = v.rs1;
      id_rs2              = v.rs2;
      id_uses_rs1         = v.u1;
      id_uses_rs2         = v.u2;
      ex_rd               = v.rd;
      ex_mem_read         = v.mr;
      ex_md_op            = v.md;
      md_done             = v.done;
      mem_access          = v.ma;
      dmem_ready          = v.rdy;
      branch_taken        = v.bt;
      branch_mispredicted = v.bm;
      perf_clr            = v.clr;
   endtask

   // Entered 1 time unit after a rising edge; returns the sampled control vector.
   task automatic cycle(input in_t v, output logic [6:0] got);
      logic [6:0] e;
      drive(v);
      #3;
      e   = model_out(v);
      got = out_vec;
      check("ctrl", got, e);
      @(posedge clk);
      #1;
      model_commit(v, e);
      check("md_timeout", md_timeout, m_to);
      check("stall_cnt", stall_cnt, m_stall);
      check("flush_cnt", flush_cnt, m_flush);
   endtask

   vec_t tbl[$];

   initial begin
      in_t v;
      logic [6:0] got;
      int n;
      int sc0, fc0;

      model_reset();
      rst_n = 1'b0;
      v = idle();
      v.md = 1'b1;
      drive(v);
      repeat (2) @(posedge clk);
      #1;
      check("reset_ctrl", out_vec, 0);
      check("reset_timeout", md_timeout, 0);
      check("reset_stall_cnt", stall_cnt, 0);
      check("reset_flush_cnt", flush_cnt, 0);
      drive(idle());
      rst_n = 1'b1;

      // Single-cycle vectors applied from RUN; none leaves the FSM busy.
      v = idle(); v.mr = 1; v.rd = 5; v.rs2 = 5; v.u2 = 1;
      tbl.push_back('{in: v, exp: 7'b1000100});
      v.rd = 0; v.rs2 = 0;
      tbl.push_back('{in: v, exp: 7'b0000000});
      v = idle(); v.mr = 1; v.rd = 7; v.rs1 = 7; v.u1 = 0; v.u2 = 1; v.rs2 = 3;
      tbl.push_back('{in: v, exp: 7'b0000000});
      v.u1 = 1;
      tbl.push_back('{in: v, exp: 7'b1000100});
      v.mr = 0;
      tbl.push_back('{in: v, exp: 7'b0000000});
      v = idle(); v.mr = 1; v.rd = 9; v.rs1 = 9; v.u1 = 1; v.bt = 1;
      tbl.push_back('{in: v, exp: 7'b0001000});
      v.bm = 1;
      tbl.push_back('{in: v, exp: 7'b0001100});
      v = idle(); v.ma = 1; v.rdy = 0; v.bm = 1;
      tbl.push_back('{in: v, exp: 7'b1110000});
      v.rdy = 1;
      tbl.push_back('{in: v, exp: 7'b0001100});
      v = idle(); v.done = 1;
      tbl.push_back('{in: v, exp: 7'b0000000});
      v = idle(); v.ma = 1; v.rdy = 0; v.md = 1;
      tbl.push_back('{in: v, exp: 7'b1110000});
      v = idle(); v.clr = 1;
      tbl.push_back('{in: v, exp: 7'b0000000});
      foreach (tbl[i]) begin
         cycle(tbl[i].in, got);
         check($sformatf("vec%0d", i), got, tbl[i].exp);
      end

      // Branch beats load-use: flush counter moves, stall counter does not.
      sc0 = stall_cnt; fc0 = flush_cnt;
      v = idle(); v.mr = 1; v.rd = 4; v.rs2 = 4; v.u2 = 1; v.bt = 1;
      cycle(v, got);
      check("bt_lu_ctrl", got, 7'b0001000);
      check("bt_lu_stall_cnt", stall_cnt, sc0);
      check("bt_lu_flush_cnt", flush_cnt, fc0 + 1);

      // MUL/DIV with md_done on the fifth cycle.
      v = idle(); v.md = 1;
      cycle(v, got);
      check("md_issue", got, 7'b1100011);
      v = idle();
      for (int i = 0; i < 3; i++) begin
         cycle(v, got);
         check("md_busy", got, 7'b1100010);
      end
      v.done = 1;
      cycle(v, got);
      check("md_done", got, 7'b0000000);
      check("md_no_timeout", md_timeout, 0);
      cycle(idle(), got);
      check("md_back_in_run", got, 7'b0000000);

      // Watchdog: md_done never arrives.
      v = idle(); v.md = 1;
      n = 0;
      cycle(v, got);
      if (got[6]) n++;
      v = idle();
      for (int i = 0; i < 10; i++) begin
         cycle(v, got);
         if (got[6]) n++;
      end
      check("wd_stall_cycles", n, MdTimeout);
      check("wd_timeout", md_timeout, 1);
      v = idle(); v.md = 1;
      cycle(v, got);
      check("wd_reissue", got, 7'b1100011);
      v = idle(); v.done = 1;
      cycle(v, got);
      check("wd_reissue_done", got, 7'b0000000);
      check("wd_sticky", md_timeout, 1);

      // Memory wait hides a mispredict until data memory completes.
      v = idle(); v.ma = 1; v.rdy = 0; v.bm = 1;
      for (int i = 0; i < 3; i++) begin
         cycle(v, got);
         check("mw_prio", got, 7'b1110000);
      end
      v.rdy = 1;
      cycle(v, got);
      check("mw_release", got, 7'b0001100);

      // Saturation and clear of the stall counter.
      v = idle(); v.clr = 1;
      cycle(v, got);
      v = idle(); v.mr = 1; v.rd = 5; v.rs2 = 5; v.u2 = 1;
      for (int i = 0; i < 20; i++) cycle(v, got);
      check("stall_sat", stall_cnt, CntMax);
      v = idle(); v.clr = 1;
      cycle(v, got);
      check("stall_clr", stall_cnt, 0);
      check("flush_clr", flush_cnt, 0);

      // Asynchronous reset while busy, ex_md_op held across it.
      v = idle(); v.md = 1;
      cycle(v, got);
      drive(v);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_ctrl", out_vec, 0);
      check("rst_async_stall_cnt", stall_cnt, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle(v, got);
      check("rst_reissue", got, 7'b1100011);
      v = idle(); v.done = 1;
      cycle(v, got);

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         v.rs1  = 5'($urandom_range(0, 3));
         v.rs2  = 5'($urandom_range(0, 3));
         v.rd   = 5'($urandom_range(0, 3));
         v.u1   = 1'($urandom_range(0, 1));
         v.u2   = 1'($urandom_range(0, 1));
         v.mr   = 1'($urandom_range(0, 1));
         v.md   = ($urandom_range(0, 7) == 0);
         v.done = ($urandom_range(0, 5) == 0);
         v.ma   = ($urandom_range(0, 2) == 0);
         v.rdy  = 1'($urandom_range(0, 1));
         v.bt   = ($urandom_range(0, 3) == 0);
         v.bm   = ($urandom_range(0, 5) == 0);
         v.clr  = ($urandom_range(0, 19) == 0);
         cycle(v, got);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
